// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver. Holds NUM_DIGITS packed BCD digits
// and scans them one at a time onto a shared ABCDEFG segment bus. Display
// data changes only at frame boundaries, so one frame never mixes old and
// new digits. The driver also provides leading-zero suppression, decimal
// points, an anti-ghost blank window and selectable output polarity.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 0,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [6:0]              Segment,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int P_W = $clog2(REFRESH_DIV);
  localparam int K_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(REFRESH_DIV - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_DIGITS - 1);
  localparam logic INV = (COMMON_ANODE != 0);

  // ABCDEFG pattern for one BCD code; codes 10-15 leave all segments dark.
  function automatic logic [6:0] decode_seg(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [P_W-1:0]          p;
  logic [K_W-1:0]          k;
  logic                    slot_end;
  logic                    frame_wrap;
  logic [4*NUM_DIGITS-1:0] pend_bcd;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic [NUM_DIGITS-1:0]   disp_dp;

  assign slot_end   = (p == P_LAST);
  assign frame_wrap = slot_end && (k == K_LAST);

  // Prescaler counts cycles within a slot; the digit index advances per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      k <= '0;
    end else if (slot_end) begin
      p <= '0;
      k <= (k == K_LAST) ? '0 : k + 1'b1;
    end else begin
      p <= p + 1'b1;
    end
  end

  // Pending register takes every load; the display register is refreshed only
  // as the scan wraps to digit 0, bypassing pending when load coincides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd <= '0;
      pend_dp  <= '0;
      disp_bcd <= '0;
      disp_dp  <= '0;
    end else begin
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
      end
      if (frame_wrap) begin
        disp_bcd <= load ? bcd_in : pend_bcd;
        disp_dp  <= load ? dp_in  : pend_dp;
      end
    end
  end

  // ---- stage p0: combinational decode of the current slot ----
  logic [3:0]            digit_p0;
  logic                  dp_p0;
  logic [NUM_DIGITS-1:0] en_p0;
  logic [K_W-1:0]        msd_p0;
  logic                  suppress_p0;
  logic                  blank_p0;
  logic [6:0]            seg_p0;
  logic                  dp_out_p0;
  logic [NUM_DIGITS-1:0] en_out_p0;

  if (BLANK_CYCLES > 0) begin : g_blank
    assign blank_p0 = (p < P_W'(BLANK_CYCLES));
  end else begin : g_no_blank
    assign blank_p0 = 1'b0;
  end

  // Select the active digit, find the most significant non-zero digit and
  // gate everything off for suppressed digits or the anti-ghost window.
  always_comb begin
    digit_p0 = 4'd0;
    dp_p0    = 1'b0;
    en_p0    = '0;
    msd_p0   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (k == K_W'(i)) begin
        digit_p0 = disp_bcd[4*i +: 4];
        dp_p0    = disp_dp[i];
        en_p0[i] = 1'b1;
      end
      if (disp_bcd[4*i +: 4] != 4'd0) begin
        msd_p0 = K_W'(i);
      end
    end
    suppress_p0 = lz_blank && (k > msd_p0);
    if (suppress_p0 || blank_p0) begin
      seg_p0    = 7'b0000000;
      dp_out_p0 = 1'b0;
      en_out_p0 = '0;
    end else begin
      seg_p0    = decode_seg(digit_p0);
      dp_out_p0 = dp_p0;
      en_out_p0 = en_p0;
    end
  end

  // ---- stage p1: registered pin outputs with polarity applied ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Segment    <= {7{INV}};
      dp_out     <= INV;
      digit_en   <= {NUM_DIGITS{INV}};
      frame_done <= 1'b0;
    end else begin
      Segment    <= seg_p0 ^ {7{INV}};
      dp_out     <= dp_out_p0 ^ INV;
      digit_en   <= en_out_p0 ^ {NUM_DIGITS{INV}};
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed 7-segment display driver built around the team's BCD-to-7-segment decode, using the same ABCDEFG segment order. It holds NUM_DIGITS packed BCD digits and time-multiplexes them onto one shared segment bus with one enable per digit. It adds:
- a refresh prescaler
- tear-free frame-synchronous update
- leading-zero suppression
- decimal points
- an anti-ghosting blank window
- selectable common-anode/common-cathode polarity

It sits between the numeric datapath and the board display pins.

## Interface
- NUM_DIGITS, 4, digit count, legal 1..8
- REFRESH_DIV, 1000, clock cycles per digit slot, minimum 2
- BLANK_CYCLES, 0, cycles at the start of each slot with the digit disabled, must be < REFRESH_DIV
- COMMON_ANODE, 0, 0 = all outputs active-high; 1 = Segment, dp_out and digit_en active-low
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- bcd_in  input  4*NUM_DIGITS  packed BCD; bits [3:0] are digit 0, the least significant digit
- dp_in  input  NUM_DIGITS  decimal point per digit
- load  input  1  capture bcd_in/dp_in into the pending register
- lz_blank  input  1  enable leading-zero suppression; sampled live, not captured
- Segment  output  7  ABCDEFG, bit 6 = A
- dp_out  output  1  decimal point of the active digit
- digit_en  output  NUM_DIGITS  one-hot digit enable; bit k drives digit k
- frame_done  output  1  one-cycle pulse per completed scan frame

## Operation
- Prescaler p, range 0..REFRESH_DIV-1:
  - p == REFRESH_DIV-1: p wraps to 0 and index k advances, wrapping NUM_DIGITS-1 -> 0.
  - Otherwise p increments.
- Pending register: loaded from bcd_in/dp_in on any edge where load=1.
- Display register: loaded only on the edge where k wraps to 0, with (load ? bcd_in/dp_in : pending). A load on the wrap cycle reaches the display with no extra frame of delay.
- Decode, codes 0-9: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Codes 10-15: segments off, digit enable still active, dp still shown.
- Leading-zero suppression (lz_blank=1): digits above the most significant non-zero digit are suppressed.
  - Suppressed digit: digit_en bit, Segment and dp_out all inactive.
  - Digit 0 is never suppressed.
- Anti-ghost blank: while p < BLANK_CYCLES, digit_en is all inactive and Segment/dp_out are off.
- Polarity: with COMMON_ANODE=1, every value above is bitwise inverted at the output register.

## Timing
- Reset, asynchronous: p=0, k=0, pending=0, display=0.
- Reset output values: Segment, dp_out and digit_en all inactive (0 for COMMON_ANODE=0, all-ones for COMMON_ANODE=1); frame_done=0.
- Outputs are registered. On each edge they load the decode of the pre-edge k, p, display register and lz_blank, so they lag the internal state by one cycle.
- First edge after reset release: digit 0 pattern is shown (BLANK_CYCLES=0).
- Each digit is enabled for REFRESH_DIV-BLANK_CYCLES consecutive cycles. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- frame_done goes high for exactly one cycle after the edge where k wraps to 0, i.e. the same edge that updates the display register.
- New data appears starting with digit 0 of the next frame. A single frame never mixes old and new digits.
- Reset asserted mid-frame: outputs go inactive immediately and asynchronously. Pending data is lost. Scanning restarts at digit 0.
- digit_en is always one-hot or all-inactive; never two digits at once.

## Test plan
1. NUM_DIGITS=4, REFRESH_DIV=4, COMMON_ANODE=0.
   - Stimulus: rst_n=0.
   - Response: Segment=0000000, digit_en=0000, dp_out=0, frame_done=0.
   - Then release reset. Response: the first edge gives digit_en=0001, Segment=1111110 for 4 cycles; frame_done pulses every 16 cycles.
2. Stimulus: load=1 with bcd_in=16'h1234 mid-frame, dp_in=4'b0100.
   - Response: the current frame keeps the old data.
   - Next frame: 0001/0110011, 0010/1111001, 0100/1101101 with dp_out=1, 1000/0110000, each held 4 cycles.
3. lz_blank=1, bcd_in=16'h0070.
   - Response: digit 0 = 1111110, digit 1 = 1110000; digits 2 and 3 have digit_en=0000 and Segment=0000000 in their slots.
   - With bcd_in=16'h0000: only digit 0 is lit, showing 0.
4. bcd_in=16'hAF09 with dp_in=4'b1000.
   - Response: digit 0 = 1111011, digit 1 = 1111110.
   - Digits 2 and 3 have enable active and segments 0000000; digit 3 has dp_out=1.
5. COMMON_ANODE=1, BLANK_CYCLES=1, load 16'h0008.
   - Response: during reset all outputs are all-ones.
   - Each slot: 1 cycle with digit_en=1111, then 3 cycles enabled; digit 0 has Segment=0000000 and digit_en=1110.
6. Boundary and reset cases.
   - Stimulus: assert load on the exact wrap cycle. Response: the data is shown in the immediately following frame.
   - Stimulus: assert rst_n=0 while digit 2 is active. Response: outputs go inactive the same cycle and scanning restarts at digit 0 with display=0.
